// File: rtl/gpp_param.sv
// rtl/gpp_param.sv - parametrised generic packet parser: forward, filter, PHV/MD capture, localbus counters
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   pktin_*                     134-bit packet words from the port/CPU input ([133:132] 01 head, 11 middle, 10 tail)
//   pktin_ready                 combinational ready, low while any downstream almost-full is raised
//   out_phv/out_phv_wr          parsed header vector, one strobe per good accepted packet
//   out_md/out_md_wr            metadata with NMID/PST inserted for locally addressed packets
//   out_data/out_data_wr        forwarded words to the data cache, 1-cycle latency
//   out_valid/out_valid_wr      packet-good flag, one strobe per forwarded packet
//   in_phv_alf/in_md_alf/in_data_alf  downstream almost-full flags
//   cfg_*                       localbus register access (async chip select, active-low ack)
module gpp_param #(
  parameter int         PHV_BEATS = 8,
  parameter logic [7:0] LMID      = 8'd1,
  parameter logic [7:0] NMID      = 8'd2,
  parameter logic [7:0] DROP_MAX  = 8'd4,
  localparam int        PHV_W     = 128 * PHV_BEATS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             pktin_data_wr,
  input  logic [133:0]     pktin_data,
  input  logic             pktin_data_valid,
  output logic             pktin_ready,
  output logic [PHV_W-1:0] out_phv,
  output logic             out_phv_wr,
  input  logic             in_phv_alf,
  output logic [255:0]     out_md,
  output logic             out_md_wr,
  input  logic             in_md_alf,
  output logic [133:0]     out_data,
  output logic             out_data_wr,
  output logic             out_valid,
  output logic             out_valid_wr,
  input  logic             in_data_alf,
  input  logic             cfg_cs_n,
  input  logic             cfg_rw,
  input  logic [31:0]      cfg_addr,
  input  logic [31:0]      cfg_wdata,
  output logic             cfg_ack_n,
  output logic [31:0]      cfg_rdata
);

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_TRANS = 2'd1, ST_DISCARD = 2'd2} state_t;
  typedef enum logic [1:0] {LB_IDLE = 2'd0, LB_WAIT = 2'd1, LB_ACK = 2'd2} lb_state_t;

  state_t            state, state_next;
  lb_state_t         lb_state, lb_next;
  logic [1:0]        lb_cnt, lb_cnt_next;

  logic [7:0]        step;
  logic [PHV_W-1:0]  phv;
  logic [255:0]      md;
  logic              emit_pend;
  logic [31:0]       in_pkt, out_pkt, discard_cnt, err_cnt;

  logic              is_head, is_tail, accept;
  logic              fwd, vld_wr, vld, emit_set, cap_head, cap_word;
  logic              inc_in, inc_out, inc_disc, inc_err;
  logic [133:0]      fwd_word;

  logic              cs_meta, cs_sync, sel, lb_start, cnt_clr;
  logic [31:0]       rd_mux;
  logic [127:0]      beat0, beat1;
  logic [7:0]        pst;
  logic [255:0]      md_rw;
  logic              unused_bits;

  assign pktin_ready = ~(in_phv_alf | in_md_alf | in_data_alf);
  assign unused_bits = ^{cfg_addr[31:10], cfg_addr[1:0], cfg_wdata};

  assign is_head = (pktin_data[133:132] == 2'b01);
  assign is_tail = (pktin_data[133:132] == 2'b10);
  assign accept  = (pktin_data[87:80] == LMID) || (pktin_data[87:80] > DROP_MAX);

  // Packet FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    fwd        = 1'b0;
    fwd_word   = pktin_data;
    vld_wr     = 1'b0;
    vld        = 1'b0;
    emit_set   = 1'b0;
    cap_head   = 1'b0;
    cap_word   = 1'b0;
    inc_in     = 1'b0;
    inc_out    = 1'b0;
    inc_disc   = 1'b0;
    inc_err    = 1'b0;
    if (pktin_data_wr) begin
      case (state)
        ST_IDLE: begin
          if (is_head) begin
            inc_in = 1'b1;
            if (accept) begin
              fwd        = 1'b1;
              cap_head   = 1'b1;
              state_next = ST_TRANS;
            end else begin
              inc_disc   = 1'b1;
              state_next = ST_DISCARD;
            end
          end else begin
            inc_err = 1'b1;
          end
        end
        ST_TRANS: begin
          if (is_head) begin
            // Unterminated packet: close it downstream as a bad packet and
            // throw away the packet that interrupted it.
            fwd        = 1'b1;
            fwd_word   = {2'b10, pktin_data[131:0]};
            vld_wr     = 1'b1;
            inc_err    = 1'b1;
            state_next = ST_DISCARD;
          end else begin
            fwd      = 1'b1;
            cap_word = 1'b1;
            if (is_tail) begin
              vld_wr     = 1'b1;
              vld        = pktin_data_valid;
              inc_out    = 1'b1;
              emit_set   = pktin_data_valid;
              state_next = ST_IDLE;
            end
          end
        end
        ST_DISCARD: begin
          if (is_tail)      state_next = ST_IDLE;
          else if (is_head) inc_err    = 1'b1;
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // PST classification from the captured header vector
  assign beat0 = phv[PHV_W-1 -: 128];
  assign beat1 = phv[PHV_W-129 -: 128];

  always_comb begin
    pst = 8'h00;
    if (beat0[31:16] == 16'h86DD) begin
      if (beat1[95:88] == 8'h06)      pst = 8'h81;
      else if (beat1[95:88] == 8'h11) pst = 8'h83;
      else                            pst = 8'h82;
    end else if (beat0[31:16] == 16'h0800) begin
      if (beat1[71:64] == 8'h06)      pst = 8'h01;
      else if (beat1[71:64] == 8'h11) pst = 8'h07;
      else                            pst = 8'h02;
    end else if (beat0[31:16] == 16'h0806) begin
      pst = 8'h03;
    end
  end

  always_comb begin
    md_rw = md;
    if (md[87:80] == LMID) begin
      md_rw[87:80] = NMID;
      md_rw[79:72] = pst;
    end
  end

  // Datapath: forwarding, capture and emission
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data     <= '0;
      out_data_wr  <= 1'b0;
      out_valid    <= 1'b0;
      out_valid_wr <= 1'b0;
      out_phv      <= '0;
      out_phv_wr   <= 1'b0;
      out_md       <= '0;
      out_md_wr    <= 1'b0;
      emit_pend    <= 1'b0;
      step         <= '0;
      phv          <= '0;
      md           <= '0;
    end else begin
      out_data_wr  <= fwd;
      out_valid_wr <= vld_wr;
      if (fwd)    out_data  <= fwd_word;
      if (vld_wr) out_valid <= vld;

      // Emission reads phv/md before a back-to-back head overwrites them.
      emit_pend  <= emit_set;
      out_phv_wr <= emit_pend;
      out_md_wr  <= emit_pend;
      if (emit_pend) begin
        out_phv <= phv;
        out_md  <= md_rw;
      end

      if (cap_head) begin
        phv        <= '0;
        md[127:0]  <= pktin_data[127:0];
        step       <= 8'd1;
      end else if (cap_word) begin
        if (step == 8'd1) md[255:128] <= pktin_data[127:0];
        for (int k = 0; k < PHV_BEATS; k++) begin
          if (step == 8'(k + 2)) phv[PHV_W-1-128*k -: 128] <= pktin_data[127:0];
        end
        if (step != 8'hFF) step <= step + 8'd1;
      end
    end
  end

  // Counters; clear wins over a simultaneous increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_pkt      <= '0;
      out_pkt     <= '0;
      discard_cnt <= '0;
      err_cnt     <= '0;
    end else if (cnt_clr) begin
      in_pkt      <= '0;
      out_pkt     <= '0;
      discard_cnt <= '0;
      err_cnt     <= '0;
    end else begin
      if (inc_in)   in_pkt      <= in_pkt + 32'd1;
      if (inc_out)  out_pkt     <= out_pkt + 32'd1;
      if (inc_disc) discard_cnt <= discard_cnt + 32'd1;
      if (inc_err)  err_cnt     <= err_cnt + 32'd1;
    end
  end

  // Localbus: synchronised select, registered read, delayed ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_meta <= 1'b1;
      cs_sync <= 1'b1;
    end else begin
      cs_meta <= cfg_cs_n;
      cs_sync <= cs_meta;
    end
  end

  assign sel     = ~cs_sync;
  assign cnt_clr = lb_start & ~cfg_rw & (cfg_addr[9:2] == 8'h00);

  always_comb begin
    rd_mux = 32'd0;
    case (cfg_addr[9:2])
      8'h01:   rd_mux = {state, 26'd0, pktin_ready, in_md_alf, in_phv_alf, in_data_alf};
      8'h02:   rd_mux = in_pkt;
      8'h03:   rd_mux = out_pkt;
      8'h04:   rd_mux = discard_cnt;
      8'h05:   rd_mux = err_cnt;
      default: rd_mux = 32'd0;
    endcase
  end

  always_comb begin
    lb_next     = lb_state;
    lb_cnt_next = lb_cnt;
    lb_start    = 1'b0;
    case (lb_state)
      LB_IDLE: begin
        if (sel) begin
          lb_start    = 1'b1;
          lb_cnt_next = 2'd0;
          lb_next     = LB_WAIT;
        end
      end
      LB_WAIT: begin
        if (lb_cnt == 2'd2) lb_next     = LB_ACK;
        else                lb_cnt_next = lb_cnt + 2'd1;
      end
      LB_ACK: begin
        if (!sel) lb_next = LB_IDLE;
      end
      default: lb_next = LB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lb_state  <= LB_IDLE;
      lb_cnt    <= 2'd0;
      cfg_ack_n <= 1'b1;
      cfg_rdata <= 32'd0;
    end else begin
      lb_state  <= lb_next;
      lb_cnt    <= lb_cnt_next;
      cfg_ack_n <= (lb_next != LB_ACK);
      if (lb_start) cfg_rdata <= cfg_rw ? rd_mux : 32'd0;
    end
  end

endmodule

// File: doc/gpp_param.md
Name: gpp_param

Overview:
- Parametrised next-generation generic packet parser at the pipeline ingress, between the port/CPU packet input and the parse/match stages and data cache.
- Forwards accepted 134-bit packet words to the data cache and filters packets by source module ID.
- Captures a configurable-depth PHV plus a 256-bit MD and emits one PHV/MD pair per accepted packet, at packet end, with a PST classification inserted.
- Adds malformed-framing recovery, counter clear and error/discard counters over the localbus.

Parameters:
- PHV_BEATS, 8, 128-bit PHV beats captured after the two MD words; legal 2..8; PHV_W = 128*PHV_BEATS.
- LMID, 8'd1, local module ID; MD rewrite trigger and always-accepted source.
- NMID, 8'd2, next module ID written into MD[87:80] on rewrite.
- DROP_MAX, 8'd4, source IDs 0..DROP_MAX other than LMID are discarded.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- pktin_data_wr  in  1  input word strobe
- pktin_data  in  134  [133:132] 01=head, 11=middle, 10=tail; [127:0] payload
- pktin_data_valid  in  1  packet-good flag, sampled on the tail word
- pktin_ready  out  1  ~(in_phv_alf | in_md_alf | in_data_alf), combinational
- out_phv  out  PHV_W  parsed header vector
- out_phv_wr  out  1  single-cycle PHV strobe
- in_phv_alf  in  1  PHV almost-full
- out_md  out  256  metadata with PST/NMID inserted
- out_md_wr  out  1  single-cycle MD strobe
- in_md_alf  in  1  MD almost-full
- out_data  out  134  forwarded word
- out_data_wr  out  1  forwarded word strobe
- out_valid  out  1  packet-good flag to the data cache
- out_valid_wr  out  1  strobe qualifying out_valid, one per forwarded packet
- in_data_alf  in  1  data almost-full
- cfg_cs_n  in  1  localbus chip select, active low, asynchronous to clk
- cfg_rw  in  1  0=write, 1=read
- cfg_addr  in  32  byte address; [9:2] selects the register
- cfg_wdata  in  32  write data
- cfg_ack_n  out  1  localbus acknowledge, active low
- cfg_rdata  out  32  read data

Behaviour:
- Interface: reset rst_n, asynchronous, active-low; clock clk. On reset all outputs are 0 except cfg_ack_n=1; the FSM enters IDLE and all counters, PHV and MD clear.
- Word index: step=0 on the head word, then increments per accepted word and saturates at 255. step 0 and 1 load MD[127:0] and MD[255:128]. step 2..PHV_BEATS+1 load PHV beat k=step-2 into PHV[PHV_W-1-128k -: 128]. The PHV clears at each head, so unwritten beats of short packets read 0.
- Accept rule: on the head, src = pktin_data[87:80]; accept if src==LMID or src>DROP_MAX.
- FSM states are IDLE, TRANS and DISCARD.
- IDLE, head, accepted: forward the word, go to TRANS, in_pkt++.
- IDLE, head, rejected: go to DISCARD, in_pkt++, discard++.
- IDLE, middle or tail word: drop it, err++, stay in IDLE.
- TRANS: forward every word with 1-cycle latency.
- TRANS, tail: out_valid=pktin_data_valid with out_valid_wr=1 in the same cycle as the forwarded tail; go to IDLE; out_pkt++.
- TRANS, head before tail: forward that word with type forced to 10 and out_valid=0/out_valid_wr=1, err++, then go to DISCARD for the remainder of the new packet.
- DISCARD: no output; a tail returns the FSM to IDLE; a head stays in DISCARD with err++.
- PST is evaluated from the captured PHV, beat0=PHV[PHV_W-1 -: 128], using the first matching rule in priority order:
  - ethertype=beat0[31:16]; v6nh=beat1[95:88]; v4proto=beat1[71:64]
  - 86DD with nh 06 -> 81
  - 86DD with nh 11 -> 83
  - 86DD -> 82
  - 0800 with proto 06 -> 01
  - 0800 with proto 11 -> 07
  - 0800 -> 02
  - 0806 -> 03
  - otherwise -> 00 (no hold of the previous value)
- PHV/MD emission: one cycle after the forwarded tail, only if the packet was accepted, its tail arrived in TRANS and pktin_data_valid=1 on the tail.
  - out_phv_wr=1 and out_md_wr=1 for exactly one cycle.
  - out_md: if MD[87:80]==LMID, MD[87:80]=NMID and MD[79:72]=PST; otherwise MD is unchanged.
  - out_phv and out_md hold between strobes.
- Emission boundaries:
  - 2-word packets emit an all-zero PHV.
  - Words beyond PHV_BEATS+1 are forwarded but not captured.
  - Back-to-back packets (tail immediately followed by head) are supported with no bubble.
- Backpressure: the upstream source stops within 2 cycles of pktin_ready=0; the block neither buffers nor drops words on alf.
- Counters: 32-bit and wrapping. A counter clear has priority over a simultaneous increment.
- Localbus:
  - cfg_cs_n passes through a 2-flop synchroniser.
  - Once the select is seen, the read is registered and cfg_ack_n goes low 3 clk later.
  - cfg_ack_n stays low until the synchronised select deasserts, then returns high and the block re-arms.
  - Register map (by cfg_addr[9:2]):
    - 0x0: write any value clears all counters; reads 0.
    - 0x1: status = {state[1:0], 26'b0, pktin_ready, md_alf, phv_alf, data_alf}.
    - 0x2: in_pkt.
    - 0x3: out_pkt.
    - 0x4: discard.
    - 0x5: err.
    - Other addresses read 0; writes to them are ignored.

Test Plan:
- IPv4/TCP 5-word packet, src=1, valid=1, PHV_BEATS=8 -> 5 words forwarded at 1-cycle latency; out_valid_wr=1 on the tail; one cycle later out_phv_wr=out_md_wr=1 with MD[87:80]=02, MD[79:72]=01, PHV beats 3..7 = 0; out_pkt=1.
- Packet src=3 -> no output strobes; discard=1; in_pkt=1. Packet src=9 -> forwarded, MD unchanged, PST omitted.
- IPv6/UDP packet with tail valid=0 -> out_valid=0 with out_valid_wr=1; no PHV/MD strobe.
- Head, middle, then head with no tail -> second head forwarded as type 10 with out_valid=0; err=1; the new packet is discarded up to its tail; the next clean packet parses normally.
- Stray tail word in IDLE -> dropped; err=1. Back-to-back ARP packets -> PST=03 for each; two PHV strobes.
- Localbus reads 0x2..0x5 after the above return expected counts; write to 0x0 reads back zeros; in_data_alf=1 -> pktin_ready=0 and status bit0=1.
